// File: rtl/ti_pkg.sv
// Shared types and elaboration helpers for the threshold-implementation LUT stage.
package ti_pkg;

  typedef enum logic [0:0] {
    ST_UNLOADED = 1'b0,
    ST_ARMED    = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while (int'(32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int chunks(input int in_w, input int cfg_w);
    return int'(32'd1 << in_w) / cfg_w;
  endfunction

endpackage

// File: rtl/ti_lut_bank.sv
// One 2**IN_W-entry truth table: chunked write port, combinational single-bit read.
module ti_lut_bank
  import ti_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int CFG_W = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_we,
  input  logic [clog2(chunks(IN_W, CFG_W))-1:0] i_chunk,
  input  logic [CFG_W-1:0]                      i_data,
  input  logic [IN_W-1:0]                       i_rd_addr,
  output logic                                  o_rd_bit
);

  localparam int LSB_W = IN_W - clog2(chunks(IN_W, CFG_W));

  logic [(2**IN_W)-1:0] r_table;
  logic [IN_W-1:0]      w_base;

  assign w_base = IN_W'(i_chunk) << LSB_W;

  // Table storage, cleared by reset so an unprogrammed function reads as constant 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_table <= '0;
    end else if (i_we) begin
      r_table[w_base +: CFG_W] <= i_data;
    end else begin
      r_table <= r_table;
    end
  end

  assign o_rd_bit = r_table[i_rd_addr];

endmodule

// File: rtl/ti_lut_stage.sv
// Programmable TI coordinate-function stage: NUM_OUT table lookups behind one output
// register, so each stage provides the glitch boundary required between TI shares.
module ti_lut_stage
  import ti_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int NUM_OUT = 4,
  parameter int CFG_W   = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_cfg_we,
  input  logic [clog2(NUM_OUT)-1:0]             i_cfg_sel,
  input  logic [clog2(chunks(IN_W, CFG_W))-1:0] i_cfg_addr,
  input  logic [CFG_W-1:0]                      i_cfg_data,
  input  logic                                  i_cfg_commit,
  input  logic                                  i_cfg_clear,
  output logic                                  o_armed,
  output logic                                  o_cfg_err,
  input  logic                                  i_in_valid,
  output logic                                  o_in_ready,
  input  logic [IN_W-1:0]                       i_in_data,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready,
  output logic [NUM_OUT-1:0]                    o_out_data
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 w_armed;
  logic                 r_cfg_err;
  logic                 r_out_valid;
  logic [NUM_OUT-1:0]   r_out_data;
  logic [NUM_OUT-1:0]   w_lut;
  logic [NUM_OUT-1:0]   w_bank_we;
  logic                 w_sel_oob;
  logic                 w_wr_ok;
  logic                 w_accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_UNLOADED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // cfg_clear wins over cfg_commit from either state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNLOADED: begin
        if (i_cfg_clear)       w_state_nxt = ST_UNLOADED;
        else if (i_cfg_commit) w_state_nxt = ST_ARMED;
        else                   w_state_nxt = ST_UNLOADED;
      end
      ST_ARMED: begin
        if (i_cfg_clear) w_state_nxt = ST_UNLOADED;
        else             w_state_nxt = ST_ARMED;
      end
      default: w_state_nxt = ST_UNLOADED;
    endcase
  end

  always_comb begin
    w_armed = 1'b0;
    case (r_state)
      ST_ARMED:    w_armed = 1'b1;
      ST_UNLOADED: w_armed = 1'b0;
      default:     w_armed = 1'b0;
    endcase
  end

  assign w_sel_oob = (int'(i_cfg_sel) >= NUM_OUT);
  assign w_wr_ok   = i_cfg_we & ~w_armed & ~i_cfg_clear & ~w_sel_oob;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_err <= 1'b0;
    end else if (i_cfg_we && (w_armed || w_sel_oob)) begin
      r_cfg_err <= 1'b1;
    end else begin
      r_cfg_err <= r_cfg_err;
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_bank
    assign w_bank_we[j] = w_wr_ok & (int'(i_cfg_sel) == j);

    ti_lut_bank #(
      .IN_W  (IN_W),
      .CFG_W (CFG_W)
    ) u_bank (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (w_bank_we[j]),
      .i_chunk   (i_cfg_addr),
      .i_data    (i_cfg_data),
      .i_rd_addr (i_in_data),
      .o_rd_bit  (w_lut[j])
    );
  end

  assign o_in_ready = w_armed & (~r_out_valid | i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;

  // Single output register; a clear discards any held result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (i_cfg_clear) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lut;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

  assign o_armed     = w_armed;
  assign o_cfg_err   = r_cfg_err;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_ti_lut_stage.sv
// Directed bench for ti_lut_stage: configuration, lookup, handshake and reset behaviour.
module tb_ti_lut_stage;

  logic       clk, rst;
  logic       cfg_we, cfg_commit, cfg_clear;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       armed, cfg_err;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data;
  logic [3:0] out_data;

  logic [255:0] tab [4];
  logic [3:0]   q [$];
  logic [3:0]   held;
  int           n_vec, n_err, sent, cycles;
  logic         exp_v, exp_rdy;

  ti_lut_stage #(.IN_W(8), .NUM_OUT(4), .CFG_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .i_cfg_commit(cfg_commit), .i_cfg_clear(cfg_clear),
    .o_armed(armed), .o_cfg_err(cfg_err),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] lookup(input logic [7:0] a);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = tab[j][a];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] s, input logic [4:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = s; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1; cyc(); cfg_commit = 1'b0;
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1; cyc(); cfg_clear = 1'b0;
  endtask

  // Send one vector with out_ready high, check it one cycle later.
  task automatic send_chk(input string tag, input logic [7:0] a, input logic [3:0] exp);
    in_valid = 1'b1; in_data = a;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_data, exp);
    cyc();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_clear = 1'b0;
    cfg_sel = 2'd0; cfg_addr = 5'd0; cfg_data = 8'd0;
    in_valid = 1'b1; in_data = 8'd0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) tab[j] = '0;
    cyc(); cyc();
    rst = 1'b0;

    // Unloaded stage must refuse input.
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_armed", armed, 0);
    end
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_data", out_data, 0);
    in_valid = 1'b0;

    wr(2'd0, 5'd0, 8'hF6);
    tab[0][7:0] = 8'hF6;
    pulse_commit();
    chk("armed_after_commit", armed, 1);
    send_chk("f6_in01", 8'h01, 4'h1);
    send_chk("f6_in03", 8'h03, 4'h0);

    // Full random load of all four tables, then a back-to-back sweep.
    pulse_clear();
    chk("armed_after_clear", armed, 0);
    for (int f = 0; f < 4; f++)
      for (int a = 0; a < 32; a++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        tab[f][a*8 +: 8] = d;
        wr(2'(f), 5'(a), d);
      end
    pulse_commit();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1 chk("sweep_ready", in_ready, 1);
      cyc();
      chk("sweep_vld", out_valid, 1);
      chk("sweep_data", out_data, lookup(8'(i)));
    end
    in_valid = 1'b0;
    cyc();
    chk("sweep_drain", out_valid, 0);

    // Random back-pressure against a queue scoreboard.
    sent = 0; cycles = 0; held = 4'h0; q.delete();
    while ((sent < 64 || q.size() != 0) && cycles < 2000) begin
      exp_v = (q.size() != 0);
      chk("bp_vld", out_valid, 32'(exp_v));
      if (exp_v) chk("bp_data", out_data, q[0]);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 64);
      in_data   = 8'($urandom_range(0, 255));
      exp_rdy   = !exp_v || out_ready;
      #1 chk("bp_ready", in_ready, 32'(exp_rdy));
      if (exp_v && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        q.push_back(lookup(in_data));
        sent++;
      end
      cycles++;
      cyc();
    end
    chk("bp_timeout", 32'(cycles < 2000), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();

    // Writes while armed are rejected and flagged.
    wr(2'd0, 5'd0, 8'hFF);
    chk("err_set", cfg_err, 1);
    send_chk("err_keep0", 8'h00, lookup(8'h00));
    send_chk("err_keep5", 8'h05, lookup(8'h05));
    pulse_clear();
    pulse_commit();
    chk("err_sticky", cfg_err, 1);
    chk("rearmed", armed, 1);

    // Write and commit in the same cycle: write lands and stage arms.
    pulse_clear();
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 5'd0; cfg_data = 8'hA5; cfg_commit = 1'b1;
    tab[1][7:0] = 8'hA5;
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("wc_armed", armed, 1);
    send_chk("wc_in00", 8'h00, lookup(8'h00));
    send_chk("wc_in01", 8'h01, lookup(8'h01));

    // cfg_clear discards a stalled result.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10;
    cyc();
    in_valid = 1'b0;
    chk("stall_vld", out_valid, 1);
    pulse_clear();
    chk("clr_vld", out_valid, 0);
    chk("clr_armed", armed, 0);

    // Reset during a stalled result is immediate and wipes tables.
    pulse_commit();
    in_valid = 1'b1; in_data = 8'h00;
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_vld", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_vld", out_valid, 0);
    chk("async_rst_armed", armed, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_data", out_data, 0);
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) tab[j] = '0;
    cyc();
    chk("post_rst_err", cfg_err, 0);
    pulse_commit();
    send_chk("zero_in01", 8'h01, 4'h0);
    send_chk("zero_inF6", 8'hF6, 4'h0);
    send_chk("zero_in00", 8'h00, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
